// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared encodings and lane helpers for the data-memory
//               responder (funct3 codes, FSM states, byte enables,
//               store replication and load extension).
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // RV32I load/store size and sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Byte enables for a store of the given size at the given byte lane
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_B:    return 4'b0001 << lane;
            F3_H:    return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data into every lane it could land in
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Natural-alignment violation for the access size in f3[1:0]
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b01:   return lane[0];
            2'b10:   return |lane;
            default: return 1'b0;
        endcase
    endfunction

    // Select the addressed byte/half from a word and sign- or zero-extend it
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            default: return word;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : DEPTH_WORDS x 32 storage, synchronous byte-enable write,
//               registered read. Contents are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane write and registered read share one clock edge
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Load/store responder for the writeback port. Sized stores,
//               fixed-latency extended loads, fault reporting instead of
//               stalling the core.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned READ_LAT    = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        loaded,
    output logic        busy,
    output logic        access_fault
);

    localparam int unsigned c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned c_CNT_W = $clog2(READ_LAT + 1);
    localparam logic [32:0] c_SPAN  = 33'(DEPTH_WORDS) << 2;
    // A single-cycle latency skips the wait state entirely
    localparam dmem_state_t c_FIRST = (READ_LAT == 1) ? DONE : WAIT;

    dmem_state_t        state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         f3_q;
    logic [1:0]         lane_q;
    logic [c_IDX_W-1:0] idx_q;
    logic               lfault_q;
    logic               spulse_q;

    logic [31:0]        w_offset;
    logic               w_oor;
    logic               w_misalign;
    logic               w_ld_illegal;
    logic               w_st_illegal;
    logic               w_idle;
    logic               w_both;
    logic               w_ld_acc;
    logic               w_st_acc;
    logic               w_ld_fault;
    logic               w_st_fault;
    logic               w_we;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_IDX_W-1:0] w_raddr;
    logic [31:0]        w_arr_rdata;

    // Address decode; a negative offset wraps to a huge value and fails the range check
    assign w_offset     = addr - BASE_ADDR;
    assign w_oor        = {1'b0, w_offset} >= c_SPAN;
    assign w_misalign   = misaligned(funct3, addr[1:0]);
    assign w_ld_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    assign w_st_illegal = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
    assign w_ld_fault   = w_oor | w_misalign | w_ld_illegal;
    assign w_st_fault   = w_oor | w_misalign | w_st_illegal;

    // Requests are only looked at in IDLE; asserting both at once is a fault
    assign w_idle       = (state_q == IDLE);
    assign w_both       = w_idle & mem_read & mem_wr;
    assign w_ld_acc     = w_idle & mem_read & ~mem_wr;
    assign w_st_acc     = w_idle & mem_wr & ~mem_read;
    assign w_we         = w_st_acc & ~w_st_fault;
    assign w_idx        = w_offset[c_IDX_W+1:2];
    // Read the incoming index at the accept edge, then keep re-reading the captured one
    assign w_raddr      = w_idle ? w_idx : idx_q;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (w_we),
        .be_i    (store_be(funct3, addr[1:0])),
        .waddr_i (w_idx),
        .wdata_i (store_data(funct3, wdata)),
        .raddr_i (w_raddr),
        .rdata_o (w_arr_rdata)
    );

    // State and latency counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the counter is preloaded with READ_LAT-1 and DONE follows its last step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (w_ld_acc) begin
                    state_d = c_FIRST;
                    cnt_d   = c_CNT_W'(READ_LAT - 1);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - c_CNT_W'(1);
                if (cnt_q == c_CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture load attributes at accept and arm the one-cycle store/collision fault pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q     <= '0;
            lane_q   <= '0;
            idx_q    <= '0;
            lfault_q <= 1'b0;
            spulse_q <= 1'b0;
        end else begin
            spulse_q <= w_both | (w_st_acc & w_st_fault);
            if (w_ld_acc) begin
                f3_q     <= funct3;
                lane_q   <= addr[1:0];
                idx_q    <= w_idx;
                lfault_q <= w_ld_fault;
            end
        end
    end

    // Outputs: data only during DONE, zeroed for a faulting load
    always_comb begin
        loaded       = 1'b0;
        busy         = 1'b0;
        access_fault = spulse_q;
        rdata        = '0;
        case (state_q)
            WAIT: busy = 1'b1;
            DONE: begin
                busy         = 1'b1;
                loaded       = 1'b1;
                access_fault = spulse_q | lfault_q;
                if (!lfault_q) begin
                    rdata = load_extend(f3_q, lane_q, w_arr_rdata);
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
